// File: rtl/mem_pkg.sv
// Shared types and constants for the line-granular main-memory arbiter.
package mem_pkg;

    localparam int CACHE_LINE_SIZE_DEFAULT = 128;
    localparam int LINE_OFFSET_BITS        = $clog2(CACHE_LINE_SIZE_DEFAULT / 8);
    localparam int MEM_LATENCY_DEFAULT     = 5;
    localparam int MEM_LINES_DEFAULT       = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-to-memory line request/response bundle; the caches drive the master side.
interface mem_arbiter_if #(
    parameter int CACHE_LINE_SIZE = 128
);

    logic                       in_imem_read_en;
    logic [31:0]                in_imem_addr;
    logic [CACHE_LINE_SIZE-1:0] out_imem_read_data;
    logic                       out_imem_ready;

    logic                       in_dmem_read_en;
    logic                       in_dmem_write_en;
    logic [31:0]                in_dmem_addr;
    logic [CACHE_LINE_SIZE-1:0] in_dmem_write_data;
    logic [CACHE_LINE_SIZE-1:0] out_dmem_read_data;
    logic                       out_dmem_ready;

    logic                       out_busy;

    modport master (
        output in_imem_read_en, in_imem_addr,
        input  out_imem_read_data, out_imem_ready,
        output in_dmem_read_en, in_dmem_write_en, in_dmem_addr, in_dmem_write_data,
        input  out_dmem_read_data, out_dmem_ready,
        input  out_busy
    );

    modport slave (
        input  in_imem_read_en, in_imem_addr,
        output out_imem_read_data, out_imem_ready,
        input  in_dmem_read_en, in_dmem_write_en, in_dmem_addr, in_dmem_write_data,
        output out_dmem_read_data, out_dmem_ready,
        output out_busy
    );

endinterface

// File: rtl/mem_arbiter_line_memory.sv
// Single-port line-wide backing array with registered read; a same-cycle write is forwarded.
module line_memory #(
    parameter  int MEM_LINES       = 4096,
    parameter  int CACHE_LINE_SIZE = 128,
    localparam int AW              = $clog2(MEM_LINES)
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [AW-1:0]              addr_i,
    input  logic [CACHE_LINE_SIZE-1:0] wdata_i,
    output logic [CACHE_LINE_SIZE-1:0] rdata_o
);

    logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_LINES];
    logic [CACHE_LINE_SIZE-1:0] rdata_q;

    // Array write and registered read port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-latency line memory shared by the I- and D-caches, one request at a time,
// round-robin between the two sides when both ask in the same cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEFAULT,
    parameter int MEM_LATENCY     = MEM_LATENCY_DEFAULT,
    parameter int MEM_LINES       = MEM_LINES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int OFF_W = $clog2(CACHE_LINE_SIZE / 8);
    localparam int CNT_W = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Truncating the shifted address gives the index modulo MEM_LINES.
    function automatic logic [IDX_W-1:0] line_of(input logic [31:0] addr);
        return IDX_W'(addr >> OFF_W);
    endfunction

    arb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    grant_e                     last_grant_q, last_grant_d;
    grant_e                     grant_q, grant_d;
    logic [IDX_W-1:0]           line_q, line_d;
    logic                       is_write_q, is_write_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;

    logic                       imem_ready_q, imem_ready_d;
    logic                       dmem_ready_q, dmem_ready_d;
    logic                       busy_q;
    logic [CACHE_LINE_SIZE-1:0] imem_data_q, dmem_data_q;

    logic                       req_i_s, req_d_s, pick_d_s;
    logic [IDX_W-1:0]           req_line_s;
    logic                       mem_we_s, mem_re_s;
    logic [IDX_W-1:0]           mem_addr_s;
    logic [CACHE_LINE_SIZE-1:0] mem_rdata_s;
    logic                       load_imem_s, load_dmem_s;

    // Request arbitration: a lone requester wins, a tie goes away from last_grant
    always_comb begin
        req_i_s = bus.in_imem_read_en;
        req_d_s = bus.in_dmem_read_en | bus.in_dmem_write_en;
        if (req_d_s && (!req_i_s || (last_grant_q == GRANT_INSTR))) begin
            pick_d_s   = 1'b1;
            req_line_s = line_of(bus.in_dmem_addr);
        end else begin
            pick_d_s   = 1'b0;
            req_line_s = line_of(bus.in_imem_addr);
        end
    end

    // FSM and request-latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= GRANT_INSTR;
            grant_q      <= GRANT_INSTR;
            line_q       <= '0;
            is_write_q   <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            line_q       <= line_d;
            is_write_q   <= is_write_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state logic; requester inputs are only sampled at grant
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        line_d       = line_q;
        is_write_d   = is_write_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_i_s || req_d_s) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_LOAD;
                    grant_d      = pick_d_s ? GRANT_DATA : GRANT_INSTR;
                    last_grant_d = grant_d;
                    line_d       = req_line_s;
                    // A write wins over a simultaneous D-side read.
                    is_write_d   = pick_d_s & bus.in_dmem_write_en;
                    wdata_d      = bus.in_dmem_write_data;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESPOND;
                end else begin
                    state_d = ACCESS;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port control and next values of the registered outputs
    always_comb begin
        mem_re_s   = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = line_q;
        case (state_q)
            IDLE: begin
                // Read at the grant edge; the result is held through ACCESS.
                mem_re_s   = 1'b1;
                mem_addr_s = req_line_s;
            end
            ACCESS: begin
                mem_addr_s = line_q;
            end
            RESPOND: begin
                mem_we_s   = is_write_q;
                mem_addr_s = line_q;
            end
            default: begin
                mem_addr_s = line_q;
            end
        endcase
        if ((state_q == ACCESS) && (state_d == RESPOND)) begin
            imem_ready_d = (grant_q == GRANT_INSTR);
            dmem_ready_d = (grant_q == GRANT_DATA);
        end else begin
            imem_ready_d = 1'b0;
            dmem_ready_d = 1'b0;
        end
        load_imem_s = imem_ready_d & ~is_write_q;
        load_dmem_s = dmem_ready_d & ~is_write_q;
    end

    // Registered ready pulses, fill data and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            imem_data_q  <= '0;
            dmem_data_q  <= '0;
        end else begin
            imem_ready_q <= imem_ready_d;
            dmem_ready_q <= dmem_ready_d;
            busy_q       <= (state_d != IDLE);
            if (load_imem_s) begin
                imem_data_q <= mem_rdata_s;
            end
            if (load_dmem_s) begin
                dmem_data_q <= mem_rdata_s;
            end
        end
    end

    line_memory #(
        .MEM_LINES       (MEM_LINES),
        .CACHE_LINE_SIZE (CACHE_LINE_SIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .re_i    (mem_re_s),
        .addr_i  (mem_addr_s),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_s)
    );

    assign bus.out_imem_ready     = imem_ready_q;
    assign bus.out_dmem_ready     = dmem_ready_q;
    assign bus.out_imem_read_data = imem_data_q;
    assign bus.out_dmem_read_data = dmem_data_q;
    assign bus.out_busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a request-level timing/data model.
module tb_mem_arbiter;

    localparam int W     = 128;
    localparam int L     = 5;
    localparam int LINES = 4096;

    typedef logic [W-1:0] line_t;
    typedef struct {
        int    cyc;
        bit    rd;
        line_t data;
    } exp_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b0;
    int    cyc   = 0;
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    bit    i_hit    = 1'b0;
    bit    d_hit    = 1'b0;
    line_t hold_i   = '0;
    line_t hold_d   = '0;
    exp_t  exp_i[$];
    exp_t  exp_d[$];
    line_t mem_m[int];
    int    free_at  = 0;
    bit    last_d   = 1'b0;

    mem_arbiter_if #(.CACHE_LINE_SIZE(W)) bus ();

    mem_arbiter #(
        .CACHE_LINE_SIZE (W),
        .MEM_LATENCY     (L),
        .MEM_LINES       (LINES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a / (W / 8)) % LINES);
    endfunction

    // Monitor: pops the scoreboard on every ready pulse and tracks held read data
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (bus.out_imem_ready) begin
                if (exp_i.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL i_spurious_ready at cycle %0d", cyc);
                end else begin
                    e = exp_i.pop_front();
                    chk("i_ready_cycle", line_t'(cyc), line_t'(e.cyc));
                    if (e.rd) hold_i = e.data;
                    i_hit = 1'b1;
                end
            end
            if (bus.out_dmem_ready) begin
                if (exp_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_spurious_ready at cycle %0d", cyc);
                end else begin
                    e = exp_d.pop_front();
                    chk("d_ready_cycle", line_t'(cyc), line_t'(e.cyc));
                    if (e.rd) hold_d = e.data;
                    d_hit = 1'b1;
                end
            end
            chk("i_read_data", bus.out_imem_read_data, hold_i);
            chk("d_read_data", bus.out_dmem_read_data, hold_d);
        end
    end

    task automatic drive_idle();
        bus.in_imem_read_en    = 1'b0;
        bus.in_imem_addr       = 32'h0;
        bus.in_dmem_read_en    = 1'b0;
        bus.in_dmem_write_en   = 1'b0;
        bus.in_dmem_addr       = 32'h0;
        bus.in_dmem_write_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("busy_in_reset", line_t'(bus.out_busy), '0);
        chk("i_ready_in_reset", line_t'(bus.out_imem_ready), '0);
        chk("d_ready_in_reset", line_t'(bus.out_dmem_ready), '0);
        chk("i_data_in_reset", bus.out_imem_read_data, '0);
        chk("d_data_in_reset", bus.out_dmem_read_data, '0);
        drive_idle();
        exp_i.delete();
        exp_d.delete();
        free_at = 0;
        last_d  = 1'b0;
        hold_i  = '0;
        hold_d  = '0;
        i_hit   = 1'b0;
        d_hit   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Model one served request: timing from the grant cycle, data from the line array
    task automatic serve(input bit is_d, input bit wr, input logic [31:0] a,
                         input line_t wd, inout int g);
        exp_t e;
        int   ln;
        ln    = line_of(a);
        e.cyc = g + L;
        e.rd  = !wr;
        if (wr) begin
            mem_m[ln] = wd;
            e.data    = '0;
        end else begin
            e.data = mem_m.exists(ln) ? mem_m[ln] : '0;
        end
        if (is_d) exp_d.push_back(e);
        else      exp_i.push_back(e);
        last_d  = is_d;
        free_at = g + L + 1;
        g       = free_at;
    endtask

    task automatic run_pair(input bit ie, input logic [31:0] ia, input bit dr, input bit dw,
                            input logic [31:0] da, input line_t dd,
                            input bit chg, input logic [31:0] ia2);
        int t0;
        int g;
        int budget;
        bit pend_i;
        bit pend_d;
        bit d_first;
        @(negedge clk);
        t0 = cyc;
        bus.in_imem_read_en    = ie;
        bus.in_imem_addr       = ia;
        bus.in_dmem_read_en    = dr;
        bus.in_dmem_write_en   = dw;
        bus.in_dmem_addr       = da;
        bus.in_dmem_write_data = dd;
        g       = (t0 > free_at) ? t0 : free_at;
        pend_i  = ie;
        pend_d  = dr | dw;
        d_first = pend_d && (!pend_i || !last_d);
        if (d_first) begin
            serve(1'b1, dw, da, dd, g);
            if (pend_i) serve(1'b0, 1'b0, ia, '0, g);
        end else if (pend_i) begin
            serve(1'b0, 1'b0, ia, '0, g);
            if (pend_d) serve(1'b1, dw, da, dd, g);
        end
        i_hit  = 1'b0;
        d_hit  = 1'b0;
        budget = 0;
        while ((pend_i || pend_d) && budget < 4 * L + 16) begin
            @(negedge clk);
            #1;
            budget++;
            if (chg && cyc == t0 + 2) bus.in_imem_addr = ia2;
            if (i_hit) begin
                i_hit = 1'b0; pend_i = 1'b0; bus.in_imem_read_en = 1'b0;
            end
            if (d_hit) begin
                d_hit = 1'b0; pend_d = 1'b0;
                bus.in_dmem_read_en = 1'b0; bus.in_dmem_write_en = 1'b0;
            end
        end
        if (pend_i || pend_d) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: pending i=%0d d=%0d after %0d cycles", pend_i, pend_d, budget);
            drive_idle();
            exp_i.delete();
            exp_d.delete();
        end
    endtask

    initial begin
        int          t0;
        int          k;
        bit          ie, dr, dw;
        logic [31:0] ai, ad;
        line_t       rd_data;

        drive_idle();
        do_reset();
        mon_en = 1'b1;

        for (int l = 0; l < 16; l++)
            run_pair(1'b0, 32'h0, 1'b0, 1'b1, 32'(l * 16), {4{16'hAAAA, 16'(l)}}, 1'b0, 32'h0);

        // I-side read of line 1, then D write/read with offset bits set
        run_pair(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        run_pair(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0020,
                 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_CAFE, 1'b0, 32'h0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0024, '0, 1'b0, 32'h0);

        // Ties after reset: D first, then D first again since I was last
        do_reset();
        run_pair(1'b1, 32'h0000_0030, 1'b1, 1'b0, 32'h0000_0064, '0, 1'b0, 32'h0);
        run_pair(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0020, '0, 1'b0, 32'h0);

        // Reset three cycles into a write of line 5 drops the write
        @(negedge clk);
        t0 = cyc;
        bus.in_dmem_write_en   = 1'b1;
        bus.in_dmem_addr       = 32'h0000_0050;
        bus.in_dmem_write_data = 128'h5555_0000_5555_0000_5555_0000_5555_0000;
        repeat (2) @(negedge clk);
        chk("busy_during_access", line_t'(bus.out_busy), line_t'(1'b1));
        do_reset();
        chk("reset_cycle_offset", line_t'(cyc - t0 >= 3), line_t'(1'b1));
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0058, '0, 1'b0, 32'h0);

        // I address changes during ACCESS; line 4 must still be returned
        run_pair(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, '0, 1'b1, 32'h0000_0080);

        // Write and read together on line 3, then read it back through I
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0030,
                 128'h3333_CCCC_3333_CCCC_1234_5678_9ABC_DEF0, 1'b0, 32'h0);
        run_pair(1'b1, 32'h0000_003C, 1'b0, 1'b0, 32'h0, '0, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(0, 5));
            ie = (k == 0) || (k == 3) || (k == 4);
            dr = (k == 1) || (k == 3) || (k == 5);
            dw = (k == 2) || (k == 4) || (k == 5);
            ai = ($urandom() & 32'hFFFF_000F) | (32'($urandom_range(0, 15)) << 4);
            ad = ($urandom() & 32'hFFFF_000F) | (32'($urandom_range(0, 15)) << 4);
            rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_pair(ie, ai, dr, dw, ad, rd_data, 1'b0, 32'h0);
        end

        repeat (3) @(negedge clk);
        chk("i_queue_drained", line_t'(exp_i.size()), '0);
        chk("d_queue_drained", line_t'(exp_d.size()), '0);
        chk("idle_at_end", line_t'(bus.out_busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Line-granular main-memory stage directly downstream of the data-cache stage (and the instruction cache).
- Consumes the caches' line read/write requests and arbitrates between the I-side and D-side with round-robin on ties.
- Models a fixed-latency, line-wide backing memory and returns the line data with a one-cycle ready pulse.
- Serves one request at a time; the caches stall on their own busy logic until ready.

Parameters:
- CACHE_LINE_SIZE, 128, line width in bits; must match both caches.
- MEM_LATENCY, 5, cycles from grant to ready pulse; must be >= 2.
- MEM_LINES, 4096, number of lines in the backing array; a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_imem_read_en  input  1  I-cache line-fill request (level).
- in_imem_addr  input  32  I-cache byte address.
- out_imem_read_data  output  CACHE_LINE_SIZE  I-side fill line.
- out_imem_ready  output  1  one-cycle I-side completion pulse.
- in_dmem_read_en  input  1  D-cache line-fill request (level).
- in_dmem_write_en  input  1  D-cache line write-back request (level).
- in_dmem_addr  input  32  D-cache byte address.
- in_dmem_write_data  input  CACHE_LINE_SIZE  D-cache write-back line.
- out_dmem_read_data  output  CACHE_LINE_SIZE  D-side fill line.
- out_dmem_ready  output  1  one-cycle D-side completion pulse.
- out_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, last_grant=INSTR.
  - Both ready outputs 0; both read_data outputs 0; out_busy 0.
  - Backing array contents are not cleared; the simulation bench preloads them.
- Requester contract:
  - The requester holds en and addr stable until it sees ready.
  - It deasserts en in the cycle after the ready pulse.
- Line index = addr[31:log2(CACHE_LINE_SIZE/8)] modulo MEM_LINES; byte-offset bits are ignored.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - If any request is pending, grant and go to ACCESS.
  - Latch at grant: granted port, line index, op (read/write) and write data.
  - Load counter with MEM_LATENCY-1.
- Arbitration in IDLE:
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not equal to last_grant wins.
  - last_grant updates at grant.
- ACCESS:
  - Counter decrements each cycle; go to RESPOND when it reaches 1 (ACCESS lasts MEM_LATENCY-1 cycles).
  - Changes to requester inputs are ignored while here.
- RESPOND (one cycle):
  - Write: commit the latched line to the array.
  - Read: drive the array line onto the granted port's read_data.
  - Pulse the granted port's ready for that cycle, then return to IDLE.
- Timing: grant in cycle T gives ready in cycle T+MEM_LATENCY. The next grant is no earlier than T+MEM_LATENCY+1.
- read_data holds its last value until that port's next read response.
- Write responses do not alter out_dmem_read_data.
- in_dmem_write_en and in_dmem_read_en high together: write only is performed; one ready pulse; the read is dropped.
- Reset during ACCESS or RESPOND aborts the in-flight request. No ready is issued, and a pending write is not committed (unless the RESPOND edge has already completed).
- Array access is synchronous with write-first ordering: a read granted after a write to the same line returns the new data.

Decomposition:
- Shared package mem_pkg holds:
  - CACHE_LINE_SIZE default and LINE_OFFSET_BITS;
  - arbiter state enum {IDLE, ACCESS, RESPOND};
  - grant enum {GRANT_INSTR, GRANT_DATA};
  - the counter width, $clog2(MEM_LATENCY+1).
- One natural sub-module: line_memory.
  - Single-port, line-wide synchronous array with write enable.
  - Parameters MEM_LINES and CACHE_LINE_SIZE.
- Arbitration and FSM stay in mem_arbiter.

Test Plan:
- I-side read:
  - Stimulus: line 1 preloaded with 128'hAAAA_0001_..._0001; in_imem_read_en=1, addr=32'h0000_0010 at cycle T.
  - Response: out_imem_ready pulses only at T+5; out_imem_read_data equals the preloaded line and holds after the pulse.
- D-side write then read:
  - Stimulus: D write addr 32'h20, data 128'hDEAD_BEEF_..._CAFE; then D read addr 32'h24.
  - Response: write ready at T+5; read returns the written line (offset ignored).
- Simultaneous requests after reset:
  - Stimulus: I read and D read both asserted at T.
  - Response: D ready at T+5, I ready at T+11.
  - A second simultaneous pair is granted D first again, because I was last.
- Reset mid-write:
  - Stimulus: assert reset at T+3 of a D write to line 5.
  - Response: no ready pulse; out_busy=0 immediately; a subsequent read of line 5 returns the old contents.
- Address change during ACCESS:
  - Stimulus: in_imem_addr changed from 32'h40 to 32'h80 at T+2.
  - Response: data returned is line 4, not line 8.
- Write and read asserted together:
  - Stimulus: in_dmem_write_en=1 and in_dmem_read_en=1 for line 3.
  - Response: exactly one out_dmem_ready pulse; line 3 updated; out_dmem_read_data unchanged.
